deadlock_cycle_tracer: RTL

- Synthesizable, parametrised deadlock detector and reporter for dataflow regions with PROC_NUM processes.
- Each process supplies a blocked flag and the index of the process it waits on (wait-for graph).
- The block debounces the blocked state, snapshots the graph and finds every dependence cycle by walking it. Each cycle is streamed out as a sequence of process IDs on a valid/ready port, for on-chip logging or a debug FIFO; no simulation-only tasks.

---
 rtl/deadlock_cycle_tracer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/deadlock_cycle_tracer.sv
// Deadlock detector for a dataflow region: debounces the blocked state, snapshots the
// wait-for graph, walks it to find every dependence cycle and streams each cycle out.
module deadlock_cycle_tracer #(
    parameter int PROC_NUM      = 4,
    parameter int IDX_W         = 2,
    parameter int CNT_W         = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PROC_NUM-1:0]       blocked,
    input  logic [PROC_NUM*IDX_W-1:0] wait_for,
    input  logic                      clear,
    output logic                      rep_valid,
    input  logic                      rep_ready,
    output logic [IDX_W-1:0]          rep_proc_id,
    output logic [CNT_W-1:0]          rep_cycle_id,
    output logic                      rep_last,
    output logic                      dl_detect,
    output logic                      report_done,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int LEN_W = $clog2(PROC_NUM + 1);
    localparam int SC_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SNAPSHOT = 3'd1;
    localparam logic [2:0] S_SELECT   = 3'd2;
    localparam logic [2:0] S_WALK     = 3'd3;
    localparam logic [2:0] S_EMIT     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]                state;
    logic [PROC_NUM-1:0]       prev_blocked;
    logic [PROC_NUM*IDX_W-1:0] prev_wait;
    logic [SC_W-1:0]           stab_cnt;
    logic [PROC_NUM-1:0]       snap_blocked;
    logic [IDX_W-1:0]          snap_wait [PROC_NUM];
    logic [PROC_NUM-1:0]       done_mask;
    logic [PROC_NUM-1:0]       visit_mask;
    logic [PROC_NUM-1:0]       origin_hot;
    logic [IDX_W-1:0]          origin;
    logic [IDX_W-1:0]          cur;
    logic [IDX_W-1:0]          path [PROC_NUM];
    logic [LEN_W-1:0]          len;
    logic [LEN_W-1:0]          idx;
    logic                      dl_r;
    logic [CNT_W-1:0]          cycle_cnt;

    logic                      stable_in;
    logic [PROC_NUM-1:0]       cand;
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_idx;
    logic [PROC_NUM-1:0]       sel_hot;
    logic [IDX_W-1:0]          nxt;
    logic [PROC_NUM-1:0]       nxt_hot;
    logic                      nxt_bad;
    logic [IDX_W-1:0]          cur_entry;
    logic                      is_last;

    assign stable_in = (|blocked) && (blocked == prev_blocked) && (wait_for == prev_wait);

    // Downward scan so the lowest pending blocked process ends up selected.
    always_comb begin
        cand      = snap_blocked & ~done_mask;
        sel_found = |cand;
        sel_idx   = '0;
        sel_hot   = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_idx    = IDX_W'(i);
                sel_hot    = '0;
                sel_hot[i] = 1'b1;
            end
        end
    end

    // An out-of-range successor decodes to an all-zero one-hot and is rejected.
    always_comb begin
        nxt     = '0;
        nxt_hot = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (cur == IDX_W'(i)) nxt = snap_wait[i];
        end
        for (int i = 0; i < PROC_NUM; i++) begin
            nxt_hot[i] = (nxt == IDX_W'(i));
        end
        nxt_bad = ~(|nxt_hot) || ~(|(nxt_hot & snap_blocked)) ||
                  (|(nxt_hot & done_mask)) || (|(nxt_hot & visit_mask));
    end

    always_comb begin
        cur_entry = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (idx == LEN_W'(i)) cur_entry = path[i];
        end
        is_last = ((idx + LEN_W'(1)) == len);
    end

    assign rep_valid    = (state == S_EMIT);
    assign rep_proc_id  = rep_valid ? cur_entry : '0;
    assign rep_cycle_id = rep_valid ? cycle_cnt : '0;
    assign rep_last     = rep_valid && is_last;
    assign dl_detect    = dl_r;
    assign report_done  = (state == S_DONE);
    assign cycle_count  = cycle_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            prev_blocked <= '0;
            prev_wait    <= '0;
            stab_cnt     <= '0;
            snap_blocked <= '0;
            done_mask    <= '0;
            visit_mask   <= '0;
            origin_hot   <= '0;
            origin       <= '0;
            cur          <= '0;
            len          <= '0;
            idx          <= '0;
            dl_r         <= 1'b0;
            cycle_cnt    <= '0;
            for (int i = 0; i < PROC_NUM; i++) begin
                snap_wait[i] <= '0;
                path[i]      <= '0;
            end
        end else if (clear) begin
            state        <= S_IDLE;
            prev_blocked <= '0;
            prev_wait    <= '0;
            stab_cnt     <= '0;
            done_mask    <= '0;
            visit_mask   <= '0;
            idx          <= '0;
            dl_r         <= 1'b0;
            cycle_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    prev_blocked <= blocked;
                    prev_wait    <= wait_for;
                    if (!stable_in) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == SC_W'(STABLE_CYCLES - 1)) begin
                        stab_cnt <= '0;
                        state    <= S_SNAPSHOT;
                    end else begin
                        stab_cnt <= stab_cnt + SC_W'(1);
                    end
                end
                // The registered copies hold the debounced graph; live inputs may already differ.
                S_SNAPSHOT: begin
                    snap_blocked <= prev_blocked;
                    for (int i = 0; i < PROC_NUM; i++) begin
                        snap_wait[i] <= prev_wait[i*IDX_W +: IDX_W];
                    end
                    dl_r      <= 1'b1;
                    done_mask <= '0;
                    state     <= S_SELECT;
                end
                S_SELECT: begin
                    if (!sel_found) begin
                        state <= S_DONE;
                    end else begin
                        origin     <= sel_idx;
                        origin_hot <= sel_hot;
                        cur        <= sel_idx;
                        path[0]    <= sel_idx;
                        len        <= LEN_W'(1);
                        visit_mask <= sel_hot;
                        state      <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (nxt == origin) begin
                        idx   <= '0;
                        state <= S_EMIT;
                    end else if (nxt_bad) begin
                        done_mask <= done_mask | origin_hot;
                        state     <= S_SELECT;
                    end else begin
                        for (int i = 0; i < PROC_NUM; i++) begin
                            if (len == LEN_W'(i)) path[i] <= nxt;
                        end
                        len        <= len + LEN_W'(1);
                        visit_mask <= visit_mask | nxt_hot;
                        cur        <= nxt;
                    end
                end
                S_EMIT: begin
                    if (rep_ready) begin
                        idx <= idx + LEN_W'(1);
                        if (is_last) begin
                            done_mask <= done_mask | visit_mask;
                            if (cycle_cnt != {CNT_W{1'b1}}) cycle_cnt <= cycle_cnt + CNT_W'(1);
                            state <= S_SELECT;
                        end
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
